dtw_query_scheduler: RTL and testbench
======================================

// Module: dtw_query_scheduler
// PURPOSE
//  Shares one query input stream and one result output stream between N_CORES dtw_core instances.
//  Dispatch side: picks a free, reference-loaded core, starts it, then forwards one query packet into that core's src FIFO.
//  Collect side: merges the cores' 3-word result packets into one output stream, packet-atomically.
//  Sits between the AXI-stream DMA FIFOs and the dtw_core array.
// PARAMETERS
//  N_CORES     4    number of dtw_core instances (2..16)
//  SQG_SIZE    250  query samples per packet; a packet is 1 qid word + SQG_SIZE sample words
//  AXIS_WIDTH  32   stream data width
// PORTS
//  clk             in   1            clock
//  rst             in   1            async reset, active-high
//  in_valid        in   1            query stream word valid
//  in_ready        out  1            query stream word accepted (xfer = valid & ready)
//  in_data         in   AXIS_WIDTH   query word
//  in_last         in   1            last word of query packet
//  core_busy       in   N_CORES      dtw_core busy
//  core_load_done  in   N_CORES      dtw_core reference loaded
//  core_rs         out  N_CORES      one-hot start pulse to dtw_core (op_mode tied to 0 outside)
//  core_wren       out  N_CORES      one-hot write enable into core src FIFOs
//  core_full       in   N_CORES      core src FIFO full
//  core_wdata      out  AXIS_WIDTH   shared write data to all core src FIFOs
//  res_valid       in   N_CORES      core result FIFO not empty
//  res_ready       out  N_CORES      one-hot read strobe to core result FIFOs
//  res_data        in   N_CORES*AXIS_WIDTH  result words, core i at [i*W +: W]
//  out_valid/out_ready/out_data/out_last  out/in/out/out 1/1/AXIS_WIDTH/1  merged result stream
//  err_short       out  1            sticky: in_last before full packet
//  err_long        out  1            sticky: packet exceeded 1+SQG_SIZE words
//  q_dispatched    out  32           count of packets dispatched (wraps)
// BEHAVIOUR
//  Reset: all outputs 0; dispatch FSM in IDLE; rr pointers 0; reserved bitmap 0.
//  eligible[i] = core_load_done[i] & ~core_busy[i] & ~reserved[i].
//  Dispatch FSM:
//   IDLE: if in_valid & |eligible -> SELECT.
//   SELECT: latch sel = first eligible at/after rr_ptr (1 cycle); set reserved[sel] -> START.
//   START: core_rs[sel]=1 each cycle until core_busy[sel] is seen high -> STREAM.
//    No writes are issued here; the core clears its FIFO while idle.
//   STREAM: in_ready = ~core_full[sel]; each xfer drives core_wren[sel]=1 and core_wdata=in_data.
//    wcnt counts words.
//    - At wcnt == SQG_SIZE+1 with in_last on the final word -> DONE.
//    - Early in_last (wcnt < SQG_SIZE+1): set err_short, go to PAD. PAD writes 0 words
//      (in_ready=0, honouring core_full) until wcnt == SQG_SIZE+1, then -> DONE.
//    - No in_last at wcnt == SQG_SIZE+1: set err_long, go to DRAIN. DRAIN sets in_ready=1 and
//      discards words (no wren) until an in_last xfer, then -> DONE.
//   DONE: q_dispatched++, rr_ptr = sel+1 (mod N_CORES) -> IDLE.
//  reserved[i] clears on a falling edge of core_busy[i] (registered busy_q & ~core_busy).
//   Falling edge has priority over a same-cycle set only for i != sel.
//  Collector: when unlocked, grant = round-robin over res_valid starting after last grant; lock.
//   While locked: out_valid = res_valid[g]; out_data = res_data[g];
//   res_ready[g] = out_valid & out_ready (other bits 0).
//   Word order is qid, position, {16'b0,minval}; out_last=1 on the 3rd word; unlock after 3rd xfer.
//   res_valid may drop mid-packet: hold the lock and stall the output.
//  Dispatch and collect run concurrently and independently; zero-latency forwarding both sides.
//  Reset mid-packet aborts: FSM to IDLE, lock released, partial packets are the host's problem.
// STRUCTURE
//  Shared package dtw_pkg: dispatch state encoding, RES_WORDS=3, QPKT_WORDS=SQG_SIZE+1.
//  One sub-module, dtw_rr_arbiter #(N): req, advance, grant one-hot/index; instantiated twice,
//  used for core select and result merge.
// TESTING
//  1 N_CORES=4, all loaded, 4 back-to-back packets -> cores 0,1,2,3 each get 251 wren; q_dispatched=4.
//  2 core 1 busy, core 2 not loaded -> packets go to 0 then 3; core_rs never pulses 1 or 2.
//  3 in_last on word 100 -> err_short=1; core gets 100 data + 151 zero writes; next packet unaffected.
//  4 260-word packet -> err_long=1; 251 writes; 9 words dropped; in_ready high through DRAIN.
//  5 results valid on cores 0 and 2 simultaneously, out_ready toggling -> 6 words, packets unmixed, out_last on words 3 and 6.
//  6 rst asserted mid-STREAM -> all outputs 0 same cycle; after release a full packet dispatches cleanly.

Source files
------------

// File: rtl/dtw_pkg.sv
// Shared definitions for the dtw_core query scheduler: dispatch FSM states and packet sizes.
package dtw_pkg;

  typedef enum logic [2:0] {
    ST_IDLE,
    ST_SELECT,
    ST_START,
    ST_STREAM,
    ST_PAD,
    ST_DRAIN,
    ST_DONE
  } disp_state_t;

  localparam int unsigned RES_WORDS = 3;

  function automatic int unsigned qpkt_words(input int unsigned sqg_size);
    return sqg_size + 1;
  endfunction

endpackage

// File: rtl/dtw_rr_arbiter.sv
// Round-robin arbiter: grants the first request at/after the pointer; advance moves
// the pointer to one past the current grant.
module dtw_rr_arbiter #(
  parameter int unsigned N = 4
) (
  input  logic                 clk,
  input  logic                 rst,
  input  logic [N-1:0]         req,
  input  logic                 advance,
  output logic [N-1:0]         grant,
  output logic [$clog2(N)-1:0] grant_idx
);

  localparam int unsigned IW = $clog2(N);

  logic [IW-1:0] ptr;
  logic          found;
  int unsigned   idx;

  always_comb begin
    grant     = '0;
    grant_idx = '0;
    found     = 1'b0;
    idx       = 0;
    for (int unsigned k = 0; k < N; k++) begin
      idx = 32'(ptr) + k;
      if (idx >= N) idx = idx - N;
      if (!found && req[IW'(idx)]) begin
        found            = 1'b1;
        grant[IW'(idx)]  = 1'b1;
        grant_idx        = IW'(idx);
      end
    end
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      ptr <= '0;
    end else if (advance) begin
      ptr <= (grant_idx == IW'(N - 1)) ? '0 : grant_idx + 1'b1;
    end
  end

endmodule

// File: rtl/dtw_query_scheduler.sv
// Shares one query stream and one result stream between N_CORES dtw_core instances:
// packet dispatch to free loaded cores, packet-atomic merge of 3-word results.
module dtw_query_scheduler
  import dtw_pkg::*;
#(
  parameter int unsigned N_CORES    = 4,
  parameter int unsigned SQG_SIZE   = 250,
  parameter int unsigned AXIS_WIDTH = 32
) (
  input  logic                          clk,
  input  logic                          rst,
  input  logic                          in_valid,
  output logic                          in_ready,
  input  logic [AXIS_WIDTH-1:0]         in_data,
  input  logic                          in_last,
  input  logic [N_CORES-1:0]            core_busy,
  input  logic [N_CORES-1:0]            core_load_done,
  output logic [N_CORES-1:0]            core_rs,
  output logic [N_CORES-1:0]            core_wren,
  input  logic [N_CORES-1:0]            core_full,
  output logic [AXIS_WIDTH-1:0]         core_wdata,
  input  logic [N_CORES-1:0]            res_valid,
  output logic [N_CORES-1:0]            res_ready,
  input  logic [N_CORES*AXIS_WIDTH-1:0] res_data,
  output logic                          out_valid,
  input  logic                          out_ready,
  output logic [AXIS_WIDTH-1:0]         out_data,
  output logic                          out_last,
  output logic                          err_short,
  output logic                          err_long,
  output logic [31:0]                   q_dispatched
);

  localparam int unsigned IW         = $clog2(N_CORES);
  localparam int unsigned QPKT_WORDS = qpkt_words(SQG_SIZE);
  localparam int unsigned CW         = $clog2(QPKT_WORDS + 1);

  disp_state_t        state, state_nx;
  logic [IW-1:0]      sel;
  logic [CW-1:0]      wcnt;
  logic [N_CORES-1:0] reserved, busy_q, eligible, d_grant;
  logic [IW-1:0]      d_idx;
  logic               d_adv, wr, set_res, short_set, long_set, xfer, last_word;

  assign eligible  = core_load_done & ~core_busy & ~reserved;
  assign last_word = (wcnt == CW'(QPKT_WORDS - 1));

  // Pointer advances at SELECT to sel+1; nothing else selects before DONE, so this
  // matches updating it on packet completion.
  dtw_rr_arbiter #(.N(N_CORES)) u_disp_arb (
    .clk       (clk),
    .rst       (rst),
    .req       (eligible),
    .advance   (d_adv),
    .grant     (d_grant),
    .grant_idx (d_idx)
  );

  always_comb begin
    state_nx   = state;
    in_ready   = 1'b0;
    core_rs    = '0;
    core_wren  = '0;
    core_wdata = '0;
    wr         = 1'b0;
    set_res    = 1'b0;
    short_set  = 1'b0;
    long_set   = 1'b0;
    d_adv      = 1'b0;
    xfer       = 1'b0;
    unique case (state)
      ST_IDLE: if (in_valid && |eligible) state_nx = ST_SELECT;
      ST_SELECT: begin
        if (|d_grant) begin
          set_res  = 1'b1;
          d_adv    = 1'b1;
          state_nx = ST_START;
        end else begin
          state_nx = ST_IDLE;
        end
      end
      ST_START: begin
        if (core_busy[sel]) state_nx = ST_STREAM;
        else                core_rs[sel] = 1'b1;
      end
      ST_STREAM: begin
        in_ready = ~core_full[sel];
        xfer     = in_valid & ~core_full[sel];
        if (xfer) begin
          core_wren[sel] = 1'b1;
          core_wdata     = in_data;
          wr             = 1'b1;
          if (last_word) begin
            if (in_last) state_nx = ST_DONE;
            else begin
              long_set = 1'b1;
              state_nx = ST_DRAIN;
            end
          end else if (in_last) begin
            short_set = 1'b1;
            state_nx  = ST_PAD;
          end
        end
      end
      ST_PAD: begin
        if (!core_full[sel]) begin
          core_wren[sel] = 1'b1;
          wr             = 1'b1;
          if (last_word) state_nx = ST_DONE;
        end
      end
      ST_DRAIN: begin
        in_ready = 1'b1;
        if (in_valid && in_last) state_nx = ST_DONE;
      end
      ST_DONE: state_nx = ST_IDLE;
      default: state_nx = ST_IDLE;
    endcase
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state        <= ST_IDLE;
      sel          <= '0;
      wcnt         <= '0;
      reserved     <= '0;
      busy_q       <= '0;
      err_short    <= 1'b0;
      err_long     <= 1'b0;
      q_dispatched <= '0;
    end else begin
      state  <= state_nx;
      busy_q <= core_busy;
      // Falling busy frees a core; a same-cycle reservation of sel wins.
      reserved <= (reserved & ~(busy_q & ~core_busy)) | (set_res ? d_grant : '0);
      if (set_res) begin
        sel  <= d_idx;
        wcnt <= '0;
      end else if (wr) begin
        wcnt <= wcnt + 1'b1;
      end
      if (short_set)         err_short    <= 1'b1;
      if (long_set)          err_long     <= 1'b1;
      if (state == ST_DONE)  q_dispatched <= q_dispatched + 32'd1;
    end
  end

  logic               locked;
  logic [IW-1:0]      g;
  logic [1:0]         rcnt;
  logic [N_CORES-1:0] c_grant;
  logic [IW-1:0]      c_idx;
  logic               c_adv;

  assign c_adv = ~locked & |c_grant;

  dtw_rr_arbiter #(.N(N_CORES)) u_res_arb (
    .clk       (clk),
    .rst       (rst),
    .req       (res_valid),
    .advance   (c_adv),
    .grant     (c_grant),
    .grant_idx (c_idx)
  );

  always_comb begin
    out_valid = locked & res_valid[g];
    out_last  = locked & (rcnt == 2'(RES_WORDS - 1));
    out_data  = '0;
    res_ready = '0;
    for (int unsigned i = 0; i < N_CORES; i++) begin
      if (locked && IW'(i) == g) out_data = res_data[i*AXIS_WIDTH +: AXIS_WIDTH];
    end
    if (out_valid && out_ready) res_ready[g] = 1'b1;
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      locked <= 1'b0;
      g      <= '0;
      rcnt   <= '0;
    end else if (!locked) begin
      if (|c_grant) begin
        locked <= 1'b1;
        g      <= c_idx;
        rcnt   <= '0;
      end
    end else if (out_valid && out_ready) begin
      if (rcnt == 2'(RES_WORDS - 1)) begin
        locked <= 1'b0;
        rcnt   <= '0;
      end else begin
        rcnt <= rcnt + 1'b1;
      end
    end
  end

endmodule

// File: tb/tb_dtw_query_scheduler.sv
// Directed bench for dtw_query_scheduler: table of dispatch scenarios plus hand-written
// result-merge and mid-packet reset sequences.
module tb_dtw_query_scheduler;
  localparam int unsigned N    = 4;
  localparam int unsigned SQG  = 250;
  localparam int unsigned W    = 32;
  localparam int unsigned QPKT = SQG + 1;

  logic           clk = 1'b0;
  logic           rst;
  logic           in_valid, in_ready, in_last;
  logic [W-1:0]   in_data;
  logic [N-1:0]   core_busy, core_load_done, core_rs, core_wren, core_full;
  logic [W-1:0]   core_wdata;
  logic [N-1:0]   res_valid, res_ready;
  logic [N*W-1:0] res_data;
  logic           out_valid, out_ready, out_last;
  logic [W-1:0]   out_data;
  logic           err_short, err_long;
  logic [31:0]    q_dispatched;

  always #5 clk = ~clk;

  dtw_query_scheduler #(.N_CORES(N), .SQG_SIZE(SQG), .AXIS_WIDTH(W)) dut (
    .clk(clk), .rst(rst),
    .in_valid(in_valid), .in_ready(in_ready), .in_data(in_data), .in_last(in_last),
    .core_busy(core_busy), .core_load_done(core_load_done), .core_rs(core_rs),
    .core_wren(core_wren), .core_full(core_full), .core_wdata(core_wdata),
    .res_valid(res_valid), .res_ready(res_ready), .res_data(res_data),
    .out_valid(out_valid), .out_ready(out_ready), .out_data(out_data), .out_last(out_last),
    .err_short(err_short), .err_long(err_long), .q_dispatched(q_dispatched)
  );

  int errors = 0;
  int checks = 0;

  task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got 0x%0h expected 0x%0h", name, act, exp);
    end
  endtask

  // Core model: busy rises after a start pulse, drops on release; optional full stalls.
  logic [N-1:0] busy_m = '0, force_busy = '0, full_m = '0;
  logic         rel = 1'b0, stall_en = 1'b0;
  int unsigned  cyc = 0;
  always @(posedge clk) begin
    cyc    <= cyc + 1;
    busy_m <= rel ? '0 : (busy_m | core_rs);
    full_m <= (stall_en && (cyc % 3 == 0)) ? '1 : '0;
  end
  assign core_busy = busy_m | force_busy;
  assign core_full = full_m;

  int unsigned  wr_cnt[N]   = '{default: 0};
  int unsigned  zero_cnt[N] = '{default: 0};
  int unsigned  rs_cnt[N]   = '{default: 0};
  int unsigned  bad_hot = 0;
  logic [W:0]   cap[$];
  logic [N-1:0] rr_s = '0;
  always @(negedge clk) begin
    for (int i = 0; i < N; i++) begin
      if (core_wren[i]) begin
        wr_cnt[i]++;
        if (core_wdata == '0) zero_cnt[i]++;
      end
      if (core_rs[i]) rs_cnt[i]++;
    end
    if ($countones(core_wren) > 1 || $countones(core_rs) > 1 || $countones(res_ready) > 1) bad_hot++;
    if (out_valid && out_ready) cap.push_back({out_last, out_data});
    rr_s <= res_ready;
  end

  // Result FIFO model; core 0 drops valid for 3 cycles after its first word.
  logic [W-1:0] rw[N][3];
  int unsigned  rpos[N] = '{default: 0};
  logic [N-1:0] ractive = '0, ld_mask = '0;
  logic         ld_req = 1'b0, tog_en = 1'b0;
  int unsigned  gap0 = 0;
  always @(posedge clk) begin
    for (int i = 0; i < N; i++) begin
      if (ld_req && ld_mask[i]) begin
        ractive[i] <= 1'b1;
        rpos[i]    <= 0;
      end else if (rr_s[i]) begin
        if (rpos[i] == 2) ractive[i] <= 1'b0;
        rpos[i] <= rpos[i] + 1;
      end
    end
    if (ractive[0] && rpos[0] == 1 && gap0 < 3) gap0 <= gap0 + 1;
    out_ready <= tog_en ? ~out_ready : 1'b1;
  end
  always_comb begin
    res_valid = '0;
    res_data  = '0;
    for (int i = 0; i < N; i++) begin
      res_valid[i] = ractive[i] && !(i == 0 && rpos[0] == 1 && gap0 < 3);
      if (rpos[i] < 3) res_data[i*W +: W] = rw[i][rpos[i]];
    end
  end

  task automatic send(input int unsigned nwords, input int unsigned last_at,
                      input logic [W-1:0] base, output int unsigned drain_stalls);
    drain_stalls = 0;
    for (int unsigned k = 1; k <= nwords; k++) begin
      int unsigned tries;
      bit          done;
      tries    = 0;
      done     = 0;
      in_valid = 1'b1;
      in_data  = base + W'(k);
      in_last  = (k == last_at);
      while (!done) begin
        @(negedge clk);
        if (in_ready) done = 1;
        else begin
          tries++;
          if (k > QPKT) drain_stalls++;
        end
        @(posedge clk); #1;
        if (!done && tries > 2000) begin
          checks++;
          errors++;
          $display("FAIL send_timeout: word %0d never accepted, required acceptance", k);
          in_valid = 1'b0;
          in_last  = 1'b0;
          return;
        end
      end
    end
    in_valid = 1'b0;
    in_last  = 1'b0;
    in_data  = '0;
  endtask

  task automatic wait_q(input logic [31:0] exp);
    int unsigned n;
    n = 0;
    while (q_dispatched !== exp && n < 3000) begin
      @(negedge clk);
      n++;
    end
    check("q_dispatched", 64'(q_dispatched), 64'(exp));
  endtask

  task automatic release_cores();
    rel = 1'b1;
    @(posedge clk); #1;
    rel = 1'b0;
    repeat (3) @(posedge clk);
    #1;
  endtask

  typedef struct {
    int unsigned  nwords;
    int unsigned  last_at;
    logic [N-1:0] load;
    logic [N-1:0] fbusy;
    logic         stall;
    int unsigned  core;
    int unsigned  writes;
    int unsigned  zeros;
    logic         short_e;
    logic         long_e;
  } vec_t;

  vec_t         tbl[9];
  int unsigned  wr0[N], zr0[N], rs0[N];
  int unsigned  ds;
  logic [W:0]   exp_cap[6];

  initial begin
    tbl[0] = '{251, 251, 4'hF, 4'h0, 1'b1, 0, 251,   0, 1'b0, 1'b0};
    tbl[1] = '{251, 251, 4'hF, 4'h0, 1'b1, 1, 251,   0, 1'b0, 1'b0};
    tbl[2] = '{251, 251, 4'hF, 4'h0, 1'b1, 2, 251,   0, 1'b0, 1'b0};
    tbl[3] = '{251, 251, 4'hF, 4'h0, 1'b1, 3, 251,   0, 1'b0, 1'b0};
    tbl[4] = '{251, 251, 4'hB, 4'h2, 1'b0, 0, 251,   0, 1'b0, 1'b0};
    tbl[5] = '{251, 251, 4'hB, 4'h2, 1'b0, 3, 251,   0, 1'b0, 1'b0};
    tbl[6] = '{100, 100, 4'hF, 4'h0, 1'b0, 0, 251, 151, 1'b1, 1'b0};
    tbl[7] = '{251, 251, 4'hF, 4'h0, 1'b0, 1, 251,   0, 1'b1, 1'b0};
    tbl[8] = '{260, 260, 4'hF, 4'h0, 1'b0, 2, 251,   0, 1'b1, 1'b1};

    rw[0][0] = 32'h0000_0011; rw[0][1] = 32'h0000_0064; rw[0][2] = 32'h0000_1234;
    rw[1][0] = 32'h0000_0A01; rw[1][1] = 32'h0000_0A02; rw[1][2] = 32'h0000_0A03;
    rw[2][0] = 32'h0000_0022; rw[2][1] = 32'h0000_00C8; rw[2][2] = 32'h0000_ABCD;
    rw[3][0] = 32'h0000_0B01; rw[3][1] = 32'h0000_0B02; rw[3][2] = 32'h0000_0B03;
    exp_cap[0] = {1'b0, 32'h0000_0011};
    exp_cap[1] = {1'b0, 32'h0000_0064};
    exp_cap[2] = {1'b1, 32'h0000_1234};
    exp_cap[3] = {1'b0, 32'h0000_0022};
    exp_cap[4] = {1'b0, 32'h0000_00C8};
    exp_cap[5] = {1'b1, 32'h0000_ABCD};

    rst            = 1'b1;
    in_valid       = 1'b0;
    in_last        = 1'b0;
    in_data        = '0;
    core_load_done = '1;
    #1;
    check("reset_in_ready",  64'(in_ready), 0);
    check("reset_core_rs",   64'(core_rs), 0);
    check("reset_core_wren", 64'(core_wren), 0);
    check("reset_res_ready", 64'(res_ready), 0);
    check("reset_out",       64'({out_valid, out_last, out_data}), 0);
    check("reset_err",       64'({err_short, err_long}), 0);
    check("reset_q",         64'(q_dispatched), 0);
    #11 rst = 1'b0;
    @(posedge clk); #1;

    for (int i = 0; i < 9; i++) begin
      core_load_done = tbl[i].load;
      force_busy     = tbl[i].fbusy;
      stall_en       = tbl[i].stall;
      wr0 = wr_cnt;
      zr0 = zero_cnt;
      rs0 = rs_cnt;
      send(tbl[i].nwords, tbl[i].last_at, 32'h1000_0000 + 32'(i << 16), ds);
      wait_q(32'(i + 1));
      stall_en = 1'b0;
      for (int c = 0; c < N; c++) begin
        check($sformatf("v%0d_wren_core%0d", i, c), 64'(wr_cnt[c] - wr0[c]),
              (c == int'(tbl[i].core)) ? 64'(tbl[i].writes) : 0);
        check($sformatf("v%0d_zero_core%0d", i, c), 64'(zero_cnt[c] - zr0[c]),
              (c == int'(tbl[i].core)) ? 64'(tbl[i].zeros) : 0);
        check($sformatf("v%0d_rs_core%0d", i, c), 64'(rs_cnt[c] != rs0[c]),
              (c == int'(tbl[i].core)) ? 64'd1 : 64'd0);
      end
      check($sformatf("v%0d_err_short", i), 64'(err_short), 64'(tbl[i].short_e));
      check($sformatf("v%0d_err_long", i),  64'(err_long),  64'(tbl[i].long_e));
      if (tbl[i].nwords > QPKT) check($sformatf("v%0d_drain_stalls", i), 64'(ds), 0);
      force_busy = '0;
      release_cores();
    end

    // Two simultaneous result packets, toggling out_ready, core 0 gap mid-packet.
    core_load_done = '1;
    ld_mask = 4'b0101;
    ld_req  = 1'b1;
    @(posedge clk); #1;
    ld_req  = 1'b0;
    tog_en  = 1'b1;
    for (int n = 0; n < 300 && cap.size() < 6; n++) @(negedge clk);
    repeat (10) @(negedge clk);
    tog_en = 1'b0;
    check("merge_word_count", 64'(cap.size()), 6);
    for (int j = 0; j < 6; j++) begin
      check($sformatf("merge_word%0d", j), (j < cap.size()) ? 64'(cap[j]) : 64'hDEAD, 64'(exp_cap[j]));
    end
    check("merge_idle_after", 64'(out_valid), 0);

    // Reset in the middle of a streamed packet.
    @(posedge clk); #1;
    send(50, 0, 32'h2000_0000, ds);
    @(negedge clk);
    check("pre_reset_streaming", 64'(in_ready), 1);
    @(posedge clk); #2;
    rst = 1'b1;
    #1;
    check("mid_rst_in_ready",  64'(in_ready), 0);
    check("mid_rst_core_rs",   64'(core_rs), 0);
    check("mid_rst_core_wren", 64'({core_wren, core_wdata}), 0);
    check("mid_rst_res_ready", 64'(res_ready), 0);
    check("mid_rst_out",       64'({out_valid, out_last, out_data}), 0);
    check("mid_rst_err",       64'({err_short, err_long}), 0);
    check("mid_rst_q",         64'(q_dispatched), 0);
    rel = 1'b1;
    @(posedge clk); #1;
    rel = 1'b0;
    rst = 1'b0;
    repeat (3) @(posedge clk);
    #1;
    wr0 = wr_cnt;
    zr0 = zero_cnt;
    send(251, 251, 32'h3000_0000, ds);
    wait_q(32'd1);
    check("post_rst_wren_core0", 64'(wr_cnt[0] - wr0[0]), 251);
    check("post_rst_zero_core0", 64'(zero_cnt[0] - zr0[0]), 0);
    check("post_rst_err",        64'({err_short, err_long}), 0);
    check("onehot_violations",   64'(bad_hot), 0);

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
